// File: rtl/d_with_sync_ff.sv
// Retiming register chain with async active-high reset.
// q is the last stage; no combinational path from d.
`timescale 1ns/1ps
module d_with_sync_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter int unsigned           STAGES      = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 1 || STAGES > 16 || WIDTH < 1) begin : g_bad_cfg
    $error("d_with_sync_ff: need WIDTH>=1 and 1<=STAGES<=16");
  end

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        stage[i] <= RESET_VALUE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: tb/tb_d_with_sync_ff.sv
// Bench for d_with_sync_ff: default 1-bit cell and an
// 8-bit, 3-stage chain resetting to 8'hA5, one scoreboard each.
`timescale 1ns/1ps
module tb_d_with_sync_ff;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       rst;
  logic       d0;
  logic       q0;
  logic [7:0] d1;
  logic [7:0] q1;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] last0;

  int n_run;
  int n_fail;

  d_with_sync_ff u_dut0 (
    .d   (d0),
    .clk (clk),
    .rst (rst),
    .q   (q0)
  );

  d_with_sync_ff #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (RV)
  ) u_dut1 (
    .d   (d1),
    .clk (clk),
    .rst (rst),
    .q   (q1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reset state: single stage has nothing pending,
  // the 3-stage chain still owes two reset values.
  task automatic fill();
    sb0 = {};
    sb1 = {RV, RV};
    last0 = 8'h00;
  endtask

  // Called just after a negedge: drive, clock, check.
  task automatic cyc(input logic dv0, input logic [7:0] dv1);
    logic [7:0] e0;
    logic [7:0] e1;
    d0 = dv0;
    d1 = dv1;
    if (!rst) begin
      sb0.push_back({7'b0, dv0});
      sb1.push_back(dv1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      chk("hold0", {7'b0, q0}, 8'h00);
      chk("hold1", q1, RV);
      fill();
    end else begin
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      last0 = e0;
      chk("data0", {7'b0, q0}, e0);
      chk("data1", q1, e1);
    end
    @(negedge clk);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst = 1'b0;
    d0  = 1'b0;
    d1  = 8'h00;
    last0 = 8'h00;

    @(posedge clk);
    #1;
    chk("first_edge", {7'b0, q0}, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("async_rst0", {7'b0, q0}, 8'h00);
    chk("async_rst1", q1, RV);
    fill();
    @(negedge clk);

    cyc(1'b0, 8'h11);
    cyc(1'b1, 8'h22);
    cyc(1'b0, 8'h33);

    d0 = 1'b1;
    d1 = 8'h01;
    #2 rst = 1'b0;
    #1;
    chk("pre_edge0", {7'b0, q0}, 8'h00);
    chk("pre_edge1", q1, RV);

    cyc(1'b1, 8'h01);
    cyc(1'b0, 8'h02);
    cyc(1'b1, 8'h03);
    cyc(1'b1, 8'h04);
    cyc(1'b0, 8'h05);

    d0 = 1'b1;
    #2;
    chk("glitch", {7'b0, q0}, last0);
    d0 = 1'b0;
    #1;
    cyc(1'b0, 8'h06);
    cyc(1'b1, 8'h07);
    chk("q_high", {7'b0, q0}, 8'h01);

    #2 rst = 1'b1;
    #1;
    chk("mid_rst0", {7'b0, q0}, 8'h00);
    chk("mid_rst1", q1, RV);
    #1 rst = 1'b0;
    fill();
    cyc(1'b1, 8'h10);
    cyc(1'b0, 8'h11);
    cyc(1'b1, 8'h12);
    cyc(1'b0, 8'h13);

    rst = 1'b1;
    d0  = 1'b1;
    d1  = 8'h77;
    @(posedge clk);
    rst <= 1'b0;
    #1;
    chk("edge_rel0", {7'b0, q0}, 8'h00);
    chk("edge_rel1", q1, RV);
    fill();
    @(negedge clk);
    cyc(1'b1, 8'h88);
    cyc(1'b0, 8'h99);
    cyc(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
